// File: rtl/pwm_decoder_if.sv
// ============================================================================
// Module   : pwm_decoder_if
// Purpose  : PWM input and measurement results shared by the decoder and its
//            consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_decoder_if;
  logic        pwm;
  logic [15:0] high_cnt;
  logic [15:0] period_cnt;
  logic        valid;
  logic        stuck_hi;
  logic        stuck_lo;
  logic [1:0]  state;

  // master: the decoder; slave: whoever drives pwm and consumes results
  modport master (
    input  pwm,
    output high_cnt, period_cnt, valid, stuck_hi, stuck_lo, state
  );

  modport slave (
    output pwm,
    input  high_cnt, period_cnt, valid, stuck_hi, stuck_lo, state
  );
endinterface

`default_nettype wire

// File: rtl/pwm_decoder.sv
// ============================================================================
// Module   : pwm_decoder
// Purpose  : Measures high time and period of a PWM waveform, flags a stuck
//            input. Define PWM_DEC_SYNC_EN to add a two-flop input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_decoder #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pwm_decoder_if.master bus
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hc_q, hc_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] high_cnt_q, high_cnt_d;
  logic [15:0] period_cnt_q, period_cnt_d;
  logic        valid_q, valid_d;
  logic        stuck_hi_q, stuck_hi_d;
  logic        stuck_lo_q, stuck_lo_d;
  logic        s_q;
  logic        s;
  logic        rise;
  logic        fall;
  logic        timeout_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == C_CNT_MAX) ? v : v + 16'd1;
  endfunction

`ifdef PWM_DEC_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], bus.pwm};
  end
  assign s = sync_q[1];
`else
  assign s = bus.pwm;
`endif

  assign rise        = s & ~s_q;
  assign fall        = ~s & s_q;
  assign idle_d      = (rise | fall) ? 16'd0 : sat_inc(idle_q);
  assign timeout_hit = ~(rise | fall) && (idle_d == TIMEOUT);

  always_comb begin
    state_d      = state_q;
    hc_d         = hc_q;
    pc_d         = pc_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    stuck_hi_d   = stuck_hi_q;
    stuck_lo_d   = stuck_lo_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          hc_d    = 16'd1;
          pc_d    = 16'd1;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          pc_d    = sat_inc(pc_q);
        end else begin
          hc_d = sat_inc(hc_q);
          pc_d = sat_inc(pc_q);
        end
      end
      LOW: begin
        if (rise) begin
          high_cnt_d   = hc_q;
          period_cnt_d = pc_q;
          valid_d      = 1'b1;
          hc_d         = 16'd1;
          pc_d         = 16'd1;
          state_d      = HIGH;
        end else begin
          pc_d = sat_inc(pc_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Setting one stuck flag clears the other so they are never both set
    if (rise) begin
      stuck_hi_d = 1'b0;
      stuck_lo_d = 1'b0;
    end else if (timeout_hit) begin
      stuck_hi_d = s;
      stuck_lo_d = ~s;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hc_q         <= 16'd0;
      pc_q         <= 16'd0;
      idle_q       <= 16'd0;
      high_cnt_q   <= 16'd0;
      period_cnt_q <= 16'd0;
      valid_q      <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
      s_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      hc_q         <= hc_d;
      pc_q         <= pc_d;
      idle_q       <= idle_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      stuck_hi_q   <= stuck_hi_d;
      stuck_lo_q   <= stuck_lo_d;
      s_q          <= s;
    end
  end

  assign bus.high_cnt   = high_cnt_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.valid      = valid_q;
  assign bus.stuck_hi   = stuck_hi_q;
  assign bus.stuck_lo   = stuck_lo_q;
  assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_decoder.sv
// ============================================================================
// Module   : tb_pwm_decoder
// Purpose  : Directed and random PWM waveforms against a period-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_decoder;

  localparam logic [15:0] TIMEOUT = 16'd1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_decoder_if bif ();

  pwm_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int n_valid = 0;

  // Reference: a period runs from one rise of the sampled input to the next;
  // its high time is the number of high samples inside it.
  bit       m_prev, m_started, m_hi, m_lo, m_valid;
  bit [1:0] m_pipe;
  int       m_ones, m_len, m_run, m_high, m_period;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int m_state();
    if (!m_started) return 0;
    return m_prev ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_started = 0; m_hi = 0; m_lo = 0; m_valid = 0;
    m_pipe = 2'b00; m_ones = 0; m_len = 0; m_run = 0; m_high = 0; m_period = 0;
  endtask

  task automatic model_edge(input bit p);
    bit s, rise, fall;
`ifdef PWM_DEC_SYNC_EN
    s      = m_pipe[1];
    m_pipe = {m_pipe[0], p};
`else
    s = p;
`endif
    rise    = s && !m_prev;
    fall    = !s && m_prev;
    m_valid = 0;
    if (rise) begin
      if (m_started) begin
        m_valid  = 1;
        m_high   = sat16(m_ones);
        m_period = sat16(m_len);
      end
      m_started = 1; m_ones = 1; m_len = 1;
      m_hi = 0; m_lo = 0; m_run = 0;
    end else begin
      if (m_started) begin
        m_len++;
        if (s) m_ones++;
      end
      m_run = fall ? 0 : m_run + 1;
      if (!fall && m_run == int'(TIMEOUT)) begin
        m_hi = s; m_lo = !s; m_started = 0;
      end
    end
    m_prev = s;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("valid",      32'(bif.valid),      32'(m_valid));
    chk("high_cnt",   32'(bif.high_cnt),   32'(m_high));
    chk("period_cnt", 32'(bif.period_cnt), 32'(m_period));
    chk("stuck_hi",   32'(bif.stuck_hi),   32'(m_hi));
    chk("stuck_lo",   32'(bif.stuck_lo),   32'(m_lo));
    chk("state",      32'(bif.state),      32'(m_state()));
  endtask

  task automatic step(input logic p);
    bif.pwm = p;
    @(posedge clk);
    model_edge(p);
    #1;
    if (bif.valid === 1'b1) n_valid++;
    check_all();
  endtask

  task automatic do_reset(input int n, input logic p);
    rst     = 1'b1;
    bif.pwm = p;
    repeat (n) begin
      @(posedge clk);
      model_reset();
      #1;
      check_all();
    end
    rst = 1'b0;
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
    end
  endtask

  initial begin
    bif.pwm = 1'b0;
    model_reset();

    // Reset, then idle low
    do_reset(4, 1'b0);
    repeat (6) step(1'b0);

    // 4/12 waveform: five rises give four measurements
    n_valid = 0;
    wave(4, 12, 5);
    chk("n_valid_4_12", 32'(n_valid), 32'd4);
    chk("hc_4_12",      32'(bif.high_cnt),   32'd4);
    chk("pc_4_12",      32'(bif.period_cnt), 32'd16);

    // Duty change 15/1 -> 11/5
    wave(15, 1, 3);
    wave(11, 5, 3);
    step(1'b1);
    repeat (2) step(1'b1);
    chk("hc_11_5", 32'(bif.high_cnt),   32'd11);
    chk("pc_11_5", 32'(bif.period_cnt), 32'd16);

    // Stuck high, then stuck low (which must drop stuck_hi)
    repeat (3) step(1'b0);
    repeat (1005) step(1'b1);
    chk("stuck_hi_set", 32'(bif.stuck_hi), 32'd1);
    chk("stuck_hi_st",  32'(bif.state),    32'd0);
    repeat (1005) step(1'b0);
    chk("stuck_lo_set", 32'(bif.stuck_lo), 32'd1);
    chk("stuck_lo_hi0", 32'(bif.stuck_hi), 32'd0);

    // Recovery: first rise clears, next rise measures
    n_valid = 0;
    wave(4, 12, 1);
    chk("stuck_lo_clr", 32'(bif.stuck_lo), 32'd0);
    chk("n_valid_recov", 32'(n_valid), 32'd0);
    wave(4, 12, 2);

    // Reset mid-high: high phase finishes while reset is held
    repeat (2) step(1'b1);
    do_reset(2, 1'b1);
    repeat (12) step(1'b0);
    n_valid = 0;
    wave(4, 12, 2);
    chk("n_valid_rst", 32'(n_valid), 32'd1);
    chk("hc_rst",      32'(bif.high_cnt),   32'd4);
    chk("pc_rst",      32'(bif.period_cnt), 32'd16);

    // One-cycle glitches and minimal periods
    wave(1, 1, 4);
    wave(1, 7, 3);

    // Random periods with occasional resets
    for (int i = 0; i < 40; i++) begin
      wave(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 1);
      if ($urandom_range(0, 9) == 0) do_reset(1, 1'($urandom_range(0, 1)));
    end
    wave(3, 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
